dec_seg_scan: RTL and testbench

- Display stage directly downstream of `dec_counter`.
- Captures up to NDIG 4-bit decimal digits (each one `dec_counter` output, digit 0 = least significant) once per display frame.
- Time-multiplexes those digits onto a shared seven-segment bus with one-hot digit enables.
- Optional leading-zero blanking; an error flag for non-decimal codes.

---
 rtl/dec_seg_scan_if.sv | 22 ++
 rtl/dec_seg_scan.sv | 114 +++++++++++
 tb/tb_dec_seg_scan.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dec_seg_scan_if.sv
// Bus between the digit source and the seven-segment scanner: frame digits in,
// multiplexed segment/enable drive plus frame status out.
interface dec_seg_scan_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] digits;
  logic              blank_lz;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic              frame_done;
  logic              err;

  modport master (
    output digits, blank_lz,
    input  seg, an, frame_done, err
  );

  modport slave (
    input  digits, blank_lz,
    output seg, an, frame_done, err
  );
endinterface

// File: rtl/dec_seg_scan.sv
// Seven-segment scanner: latches a frame of decimal digits once per scan frame and
// time-multiplexes it onto a shared segment bus with one-hot digit enables.
module dec_seg_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  dec_seg_scan_if.slave  bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  logic [DW-1:0]   div_cnt;
  logic [IW-1:0]   idx;
  logic [3:0]      frame_buf [NDIG];
  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;
  logic            frame_done_q;
  logic            err_q;

  logic            div_wrap;
  logic            eof;
  logic [NDIG-1:0] zero_from;
  logic [3:0]      cur_digit;
  logic            cur_blank;
  logic            any_bad;
  logic [6:0]      seg_next;
  logic [NDIG-1:0] an_next;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign eof      = div_wrap && (idx == IDX_LAST);

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    any_bad   = 1'b0;
    // zero_from[i] is set when digit i and every more significant digit are zero
    for (int i = NDIG - 1; i >= 0; i--) begin
      acc          = acc && (frame_buf[i] == 4'd0);
      zero_from[i] = acc;
    end
    // Explicit select keeps a non-power-of-two NDIG from indexing past the buffer
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = frame_buf[i];
        cur_blank = (i != 0) && zero_from[i];
      end
    end
    for (int i = 0; i < NDIG; i++) begin
      if (bus.digits[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
    an_next  = NDIG'(1) << idx;
    seg_next = (bus.blank_lz && cur_blank) ? 7'h00 : seg_decode(cur_digit);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      idx          <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the frame buffer is cleared on reset on purpose: the display right
      // after reset must show a defined all-zero frame, not stale digits.
      for (int i = 0; i < NDIG; i++) frame_buf[i] <= 4'd0;
    end else begin
      seg_q        <= seg_next;
      an_q         <= an_next;
      div_cnt      <= div_wrap ? '0 : div_cnt + 1'b1;
      frame_done_q <= eof;
      if (div_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (eof) begin
        for (int i = 0; i < NDIG; i++) frame_buf[i] <= bus.digits[4*i +: 4];
        err_q <= any_bad;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_dec_seg_scan.sv
// Bench for dec_seg_scan: a time-based reference model checked every cycle on a
// 4x4 build and a 3-digit SCAN_DIV=1 build, plus directed literal expectations.
module tb_dec_seg_scan;

  localparam int N1 = 4, S1 = 4;
  localparam int N2 = 3, S2 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_seg_scan_if #(.NDIG(N1)) if1 ();
  dec_seg_scan_if #(.NDIG(N2)) if2 ();

  dec_seg_scan #(.NDIG(N1), .SCAN_DIV(S1)) u_main (.clk(clk), .reset(rst), .bus(if1));
  dec_seg_scan #(.NDIG(N2), .SCAN_DIV(S2)) u_fast (.clk(clk), .reset(rst), .bus(if2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Segment patterns straight from the decode table, g..a
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

  function automatic logic [31:0] shown(input logic [31:0] cap, input int n, input int d,
                                        input logic blank);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = d; j < n; j++) if (cap[4*j +: 4] != 4'd0) all_zero = 1'b0;
    if (blank && d > 0 && all_zero) return 32'h0;
    return 32'(seg_tbl[cap[4*d +: 4]]);
  endfunction

  function automatic logic has_bad(input logic [31:0] dig, input int n);
    for (int j = 0; j < n; j++) if (dig[4*j +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Model: outputs follow purely from the edge count since reset release
  int          k1, k2, ecount;
  logic [31:0] cap1, cap2;
  logic [31:0] e_seg1, e_an1, e_seg2, e_an2;
  logic        e_fd1, e_err1, e_fd2, e_err2;
  logic        live = 1'b0;

  always @(posedge clk) begin
    int p, d;
    if (rst) begin
      k1 = 0; k2 = 0; ecount = 0; cap1 = 0; cap2 = 0;
      e_seg1 = 0; e_an1 = 0; e_fd1 = 0; e_err1 = 0;
      e_seg2 = 0; e_an2 = 0; e_fd2 = 0; e_err2 = 0;
      live = 1'b1;
    end else begin
      p = k1 % (N1 * S1); d = p / S1;
      e_an1  = 32'(1) << d;
      e_seg1 = shown(cap1, N1, d, if1.blank_lz);
      e_fd1  = (p == N1 * S1 - 1);
      if (e_fd1) begin cap1 = 32'(if1.digits); e_err1 = has_bad(cap1, N1); end
      k1++;
      p = k2 % (N2 * S2); d = p / S2;
      e_an2  = 32'(1) << d;
      e_seg2 = shown(cap2, N2, d, if2.blank_lz);
      e_fd2  = (p == N2 * S2 - 1);
      if (e_fd2) begin cap2 = 32'(if2.digits); e_err2 = has_bad(cap2, N2); end
      k2++;
      ecount++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("m_seg", 32'(if1.seg), e_seg1);
      check("m_an",  32'(if1.an),  e_an1);
      check("m_fd",  32'(if1.frame_done), 32'(e_fd1));
      check("m_err", 32'(if1.err), 32'(e_err1));
      check("f_seg", 32'(if2.seg), e_seg2);
      check("f_an",  32'(if2.an),  e_an2);
      check("f_fd",  32'(if2.frame_done), 32'(e_fd2));
      check("f_err", 32'(if2.err), 32'(e_err2));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int e);
    int guard = 0;
    while (ecount != e && guard < 300) begin
      tick(1);
      guard++;
    end
    check("reach_edge", 32'(ecount), 32'(e));
  endtask

  task automatic set_digits(input logic [15:0] v);
    if1.digits = v;
    if2.digits = v[11:0];
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg);
    check({name, "_an"},  32'(if1.an),  32'(an));
    check({name, "_seg"}, 32'(if1.seg), 32'(seg));
  endtask

  initial begin
    set_digits(16'h0000);
    if1.blank_lz = 1'b0;
    if2.blank_lz = 1'b0;
    tick(3);
    lit("rst", 4'h0, 7'h00);
    check("rst_fd",  32'(if1.frame_done), 32'd0);
    check("rst_err", 32'(if1.err), 32'd0);
    rst = 1'b0;

    goto(1);
    lit("e1", 4'h1, 7'h3F);
    check("f_e1_an", 32'(if2.an), 32'h1);
    set_digits(16'h1234);
    goto(2);  check("f_e2_an", 32'(if2.an), 32'h2);
    goto(3);  check("f_e3_an", 32'(if2.an), 32'h4);
              check("f_e3_fd", 32'(if2.frame_done), 32'd1);
    goto(4);  check("f_e4_seg", 32'(if2.seg), 32'h66);
    goto(15); check("e15_fd", 32'(if1.frame_done), 32'd0);
    goto(16); check("e16_fd", 32'(if1.frame_done), 32'd1);
              check("e16_err", 32'(if1.err), 32'd0);
    goto(17); lit("d0", 4'h1, 7'h66);
    goto(21); lit("d1", 4'h2, 7'h4F);
    goto(25); lit("d2", 4'h4, 7'h5B);
    goto(29); lit("d3", 4'h8, 7'h06);
    goto(33); lit("again", 4'h1, 7'h66);

    set_digits(16'h5678);
    goto(37); lit("tearfree", 4'h2, 7'h4F);
    goto(48); check("e48_fd", 32'(if1.frame_done), 32'd1);
    goto(49); lit("new_d0", 4'h1, 7'h7F);

    set_digits(16'h0070);
    if1.blank_lz = 1'b1;
    if2.blank_lz = 1'b1;
    goto(65); lit("bl_d0", 4'h1, 7'h3F);
    goto(69); lit("bl_d1", 4'h2, 7'h07);
    goto(73); lit("bl_d2", 4'h4, 7'h00);
    goto(77); lit("bl_d3", 4'h8, 7'h00);
    if1.blank_lz = 1'b0;
    if2.blank_lz = 1'b0;
    goto(78); lit("nobl_d3", 4'h8, 7'h3F);
    goto(89); lit("nobl_d2", 4'h4, 7'h3F);

    set_digits(16'h00A3);
    goto(96);  check("e96_err", 32'(if1.err), 32'd1);
    goto(101); lit("inv_d1", 4'h2, 7'h79);
    set_digits(16'h0003);
    goto(111); check("e111_err", 32'(if1.err), 32'd1);
    goto(112); check("e112_err", 32'(if1.err), 32'd0);

    goto(120);
    rst = 1'b1;
    tick(1);
    lit("midrst", 4'h0, 7'h00);
    check("midrst_fd", 32'(if1.frame_done), 32'd0);
    check("f_midrst_an", 32'(if2.an), 32'd0);
    tick(1);
    rst = 1'b0;
    goto(1);  lit("rel_d0", 4'h1, 7'h3F);
    goto(16); check("rel_fd", 32'(if1.frame_done), 32'd1);
    goto(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
